// File: rtl/sr_drive_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// sr_drive_ctrl
//
// Command front-end for a downstream SR flip-flop. Raw set/clear requests are
// synchronised, debounced and edge-detected. A small FSM then turns each
// accepted event into a registered s or r pulse. It checks the flip-flop's q
// feedback once the pulse has finished and keeps sticky status flags.
// s and r are derived from a single latched direction bit, so they can never
// be high together.
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   synchronous, active-high reset
//   set_in    in   raw set request (asynchronous level, may bounce)
//   clr_in    in   raw clear request (asynchronous level, may bounce)
//   q_fb      in   q output of the downstream SR flip-flop
//   flag_clr  in   single-cycle pulse clearing conflict, fb_err and drop_cnt
//   s         out  registered set drive
//   r         out  registered reset drive
//   busy      out  high while the FSM is not idle
//   conflict  out  sticky: set and clear events arrived in the same cycle
//   fb_err    out  sticky: q_fb disagreed with the commanded value
//   drop_cnt  out  saturating count of discarded events
// ---------------------------------------------------------------------------
module sr_drive_ctrl #(
    parameter int SYNC_STAGES    = 2,
    parameter int DB_CYCLES      = 4,
    parameter int PULSE_CYCLES   = 1,
    parameter int HOLDOFF_CYCLES = 2,
    parameter int CLR_PRIORITY   = 1,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set_in,
    input  logic             clr_in,
    input  logic             q_fb,
    input  logic             flag_clr,
    output logic             s,
    output logic             r,
    output logic             busy,
    output logic             conflict,
    output logic             fb_err,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam int DB_W    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES + 1) : 1;
    localparam int TMR_W   = $clog2(PULSE_CYCLES + HOLDOFF_CYCLES + 1);
    localparam int HO_LAST = (HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0;

    // Channel 0 carries set, channel 1 carries clear.
    logic [1:0] raw_in;
    logic [1:0] evt;

    assign raw_in = {clr_in, set_in};

    // ---------------- per-channel synchroniser / debouncer / edge detect ----
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            logic [SYNC_STAGES-1:0] sync_q, sync_d;
            logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
            logic                   deb_q, deb_d;
            logic                   deb_dly_q, deb_dly_d;

            always_comb begin
                sync_d    = {sync_q[SYNC_STAGES-2:0], raw_in[gi]};
                db_cnt_d  = '0;
                deb_d     = deb_q;
                deb_dly_d = deb_q;
                // The counter only survives an unbroken run of cycles that
                // disagree with the accepted level. Any agreeing cycle restarts it.
                if (sync_q[SYNC_STAGES-1] != deb_q) begin
                    if (db_cnt_q == DB_W'(DB_CYCLES - 1)) begin
                        deb_d    = ~deb_q;
                        db_cnt_d = '0;
                    end else begin
                        db_cnt_d = db_cnt_q + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    sync_q    <= '0;
                    db_cnt_q  <= '0;
                    deb_q     <= 1'b0;
                    deb_dly_q <= 1'b0;
                end else begin
                    sync_q    <= sync_d;
                    db_cnt_q  <= db_cnt_d;
                    deb_q     <= deb_d;
                    deb_dly_q <= deb_dly_d;
                end
            end

            // Rising edge of the debounced level only.
            assign evt[gi] = deb_q & ~deb_dly_q;
        end
    endgenerate

    // ---------------- command FSM -------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PULSE,
        ST_CHECK,
        ST_HOLDOFF
    } state_t;

    state_t             state_q, state_d;
    logic               dir_q, dir_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic               s_q, s_d;
    logic               r_q, r_d;
    logic               conflict_q, conflict_d;
    logic               fb_err_q, fb_err_d;
    logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0]   drop_base;
    logic [1:0]         drop_inc;
    logic [CNT_W:0]     drop_sum;

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        tmr_d      = tmr_q;
        conflict_d = conflict_q;
        fb_err_d   = fb_err_q;
        drop_inc   = 2'd0;

        // flag_clr zeroes the flags first. A set condition later in this
        // block overrides the clear in the same cycle.
        if (flag_clr) begin
            conflict_d = 1'b0;
            fb_err_d   = 1'b0;
            drop_base  = '0;
        end else begin
            drop_base  = drop_cnt_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (evt != 2'b00) begin
                    state_d = ST_PULSE;
                    tmr_d   = '0;
                    if (&evt) begin
                        conflict_d = 1'b1;
                        drop_inc   = 2'd1;
                        dir_d      = (CLR_PRIORITY == 0);
                    end else begin
                        dir_d      = evt[0];
                    end
                end
            end
            ST_PULSE: begin
                if (tmr_q == TMR_W'(PULSE_CYCLES - 1)) begin
                    state_d = ST_CHECK;
                    tmr_d   = '0;
                end else begin
                    tmr_d   = tmr_q + 1'b1;
                end
            end
            ST_CHECK: begin
                if (q_fb != dir_q) begin
                    fb_err_d = 1'b1;
                end
                state_d = (HOLDOFF_CYCLES == 0) ? ST_IDLE : ST_HOLDOFF;
                tmr_d   = '0;
            end
            ST_HOLDOFF: begin
                if (tmr_q == TMR_W'(HO_LAST)) begin
                    state_d = ST_IDLE;
                end else begin
                    tmr_d   = tmr_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // While busy, every event this cycle is discarded.
        if (state_q != ST_IDLE) begin
            drop_inc = {1'b0, evt[0]} + {1'b0, evt[1]};
        end

        drop_sum = {1'b0, drop_base} + (CNT_W + 1)'(drop_inc);
        if (drop_sum[CNT_W]) begin
            drop_cnt_d = '1;
        end else begin
            drop_cnt_d = drop_sum[CNT_W-1:0];
        end

        // Outputs are registered from the next state, so a pulse starts on the
        // same edge the FSM enters PULSE. Both come from one dir bit.
        s_d = (state_d == ST_PULSE) &&  dir_d;
        r_d = (state_d == ST_PULSE) && !dir_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            dir_q      <= 1'b0;
            tmr_q      <= '0;
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            conflict_q <= 1'b0;
            fb_err_q   <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            tmr_q      <= tmr_d;
            s_q        <= s_d;
            r_q        <= r_d;
            conflict_q <= conflict_d;
            fb_err_q   <= fb_err_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign s        = s_q;
    assign r        = r_q;
    assign busy     = (state_q != ST_IDLE);
    assign conflict = conflict_q;
    assign fb_err   = fb_err_q;
    assign drop_cnt = drop_cnt_q;

endmodule
